loop_counter_ctrl: RTL and testbench
====================================

// Module: loop_counter_ctrl
// PURPOSE
//  Loop sequencer that drives the 4-bit loop-counter storage register over its write port
//  and reads its value back. It clears the counter, issues one iteration index per datapath
//  handshake, increments the counter and signals completion.
//  Sits between the interpolation top-level FSM (START/DONE) and the datapath (ITER_VALID/STEP_READY).
// PARAMETERS
//  CNT_W    4   counter width; must equal the counter register width
// PORTS
//  CLK           in   1      clock, all state updates on rising edge
//  RST_ASYNC_N   in   1      asynchronous active-low reset
//  START         in   1      start a loop; sampled only in IDLE
//  LOOP_LIMIT    in   CNT_W  iteration count N (0..2^CNT_W-1); latched on START
//  CNT_VALUE     in   CNT_W  current counter register output (read-back)
//  STEP_READY    in   1      datapath accepts the current iteration
//  CNT_WRITE_EN  out  1      write enable to the counter register
//  CNT_DATA_IN   out  CNT_W  write data to the counter register
//  ITER_VALID    out  1      an iteration index is offered (index = CNT_VALUE)
//  BUSY          out  1      high in every state except IDLE
//  DONE          out  1      one-cycle pulse when the loop completes
// BEHAVIOUR
//  - Reset: state=IDLE, limit_q=0; all outputs 0. Reset mid-loop aborts silently (no DONE).
//  - States: IDLE, CLEAR, ISSUE, FINISH. Outputs are decoded from state; CNT_WRITE_EN/CNT_DATA_IN in ISSUE are Mealy.
//  - IDLE: on START=1, limit_q<=LOOP_LIMIT, go to CLEAR. Otherwise stay.
//  - CLEAR (1 cycle): CNT_WRITE_EN=1, CNT_DATA_IN=0. Next state is FINISH if limit_q==0, else ISSUE.
//  - ISSUE: ITER_VALID=1. Transfer happens on ITER_VALID&&STEP_READY in the same cycle.
//    No transfer: hold ITER_VALID, no write.
//    Transfer with CNT_VALUE!=limit_q-1: CNT_WRITE_EN=1 and CNT_DATA_IN=CNT_VALUE+1 in that cycle; stay in ISSUE.
//    Transfer with CNT_VALUE==limit_q-1: no write; go to FINISH.
//  - Throughput: 1 iteration/cycle with STEP_READY held high. Latency START->first ITER_VALID = 2 cycles.
//  - FINISH (1 cycle): DONE=1, BUSY=1; next state is IDLE.
//    DONE and START overlap is impossible; the earliest restart is the cycle after FINISH.
//  - START outside IDLE is ignored. LOOP_LIMIT changes after the START cycle are ignored.
//  - Width: the increment is computed in CNT_W bits. No wrap occurs because the maximum written value is limit_q-1 <= 2^CNT_W-2.
//  - The counter is left holding N-1 after completion (or 0 if N==0); it is cleared again on the next START.
// CONFIGURATION
//  LOOP_CNT_ABORT_EN defined:
//    Adds input ABORT (1 bit) and output ABORTED (1 bit).
//    ABORT=1 in CLEAR/ISSUE/FINISH: that cycle forces CNT_WRITE_EN=1, CNT_DATA_IN=0, ITER_VALID=0 and no DONE.
//    In that case the next state is IDLE and ABORTED pulses for 1 cycle.
//    ABORT in IDLE has no effect. ABORT has priority over STEP_READY and over FINISH->DONE.
//  LOOP_CNT_ABORT_EN undefined: the ports are absent; the loop always runs to DONE.
// STRUCTURE
//  - Shared package loop_ctrl_pkg holds:
//    the CNT_W default constant;
//    the state encoding (IDLE=2'd0, CLEAR=2'd1, ISSUE=2'd2, FINISH=2'd3);
//    the function last_iter(cnt, limit).
//  - Single module, no sub-modules. The counter storage stays external so other loop users can read it.
// TESTING
//  - Reset: assert RST_ASYNC_N=0 mid-ISSUE -> outputs go to 0 immediately; after release state=IDLE, no DONE.
//  - N=3, STEP_READY=1 constant -> CLEAR write 0; ITER_VALID for indices 0,1,2 on consecutive cycles;
//    writes of 1,2 only; DONE 1 cycle later; BUSY high for 5 cycles.
//  - N=3, STEP_READY toggles 0/1 -> index holds while STEP_READY=0; exactly 3 transfers, DONE once.
//  - N=0 -> CLEAR, then FINISH: DONE 2 cycles after START; ITER_VALID never asserted.
//  - N=15 -> 15 transfers, last index 14, no write of 15; START pulses during BUSY are ignored;
//    back-to-back START in the cycle after DONE restarts with a clear.
//  - LOOP_CNT_ABORT_EN: N=8, ABORT at index 4 -> write 0, ABORTED pulse, no DONE, back in IDLE next cycle.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop sequencer: default counter width,
// sequencer state encoding and the last-iteration test.
package loop_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // True when cnt is the final index of a loop of 'limit' iterations.
  // Only meaningful for limit >= 1; the sequencer never issues when limit is 0.
  function automatic logic last_iter(input logic [CNT_W_DEFAULT-1:0] cnt,
                                     input logic [CNT_W_DEFAULT-1:0] limit);
    return cnt == (limit - CNT_W_DEFAULT'(1));
  endfunction

endpackage

// File: rtl/loop_counter_ctrl.sv
// Loop sequencer: clears an external loop-counter register, offers one
// iteration index (the register's read-back value) per datapath handshake,
// increments the register after each accepted index and pulses DONE at the end.
// The counter storage lives outside so other loop users can read it.
//
// Handshake: an iteration transfers in any cycle where ITER_VALID && STEP_READY;
// ITER_VALID is held (index unchanged) until STEP_READY is seen.
//
// Optional feature: define LOOP_CNT_ABORT_EN to add the ABORT input and the
// ABORTED output. Without it the loop always runs to DONE.
module loop_counter_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             START,
  input  logic [CNT_W-1:0] LOOP_LIMIT,
  input  logic [CNT_W-1:0] CNT_VALUE,
  input  logic             STEP_READY,
`ifdef LOOP_CNT_ABORT_EN
  input  logic             ABORT,
  output logic             ABORTED,
`endif
  output logic             CNT_WRITE_EN,
  output logic [CNT_W-1:0] CNT_DATA_IN,
  output logic             ITER_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  state_t           r_state;
  logic [CNT_W-1:0] r_limit;
  logic             w_abort;
  logic             w_last;
  logic [CNT_W-1:0] w_incr;

`ifdef LOOP_CNT_ABORT_EN
  logic r_aborted;
  assign w_abort = ABORT && (r_state != ST_IDLE);
  assign ABORTED = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Increment stays in CNT_W bits; the largest value ever written is limit-1.
  assign w_last    = last_iter(CNT_VALUE, r_limit);
  assign w_incr    = CNT_VALUE + CNT_W'(1);
  assign DBG_STATE = r_state;

  // Output decode: Moore from state, except the ISSUE-state write which depends on the handshake.
  always_comb begin
    BUSY         = (r_state != ST_IDLE);
    ITER_VALID   = (r_state == ST_ISSUE) && !w_abort;
    DONE         = (r_state == ST_FINISH) && !w_abort;
    CNT_WRITE_EN = 1'b0;
    CNT_DATA_IN  = '0;
    if (w_abort) begin
      CNT_WRITE_EN = 1'b1;
    end else if (r_state == ST_CLEAR) begin
      CNT_WRITE_EN = 1'b1;
    end else if ((r_state == ST_ISSUE) && STEP_READY && !w_last) begin
      CNT_WRITE_EN = 1'b1;
      CNT_DATA_IN  = w_incr;
    end
  end

  // Sequencer state, latched loop limit and (optionally) the abort pulse.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_state   <= ST_IDLE;
      r_limit   <= '0;
`ifdef LOOP_CNT_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
`ifdef LOOP_CNT_ABORT_EN
      r_aborted <= w_abort;
`endif
      if (w_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START) begin
              r_limit <= LOOP_LIMIT;
              r_state <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            r_state <= (r_limit == '0) ? ST_FINISH : ST_ISSUE;
          end
          ST_ISSUE: begin
            if (STEP_READY && w_last) begin
              r_state <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_counter_ctrl.sv
// Bench for loop_counter_ctrl. The bench owns the external counter register.
// Expected iteration indices, DONE events and counter writes are queued when a
// loop is started; a monitor pops and compares them as the DUT presents them.
module tb_loop_counter_ctrl;
  import loop_ctrl_pkg::*;

  localparam int W = CNT_W_DEFAULT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] loop_limit;
  logic [W-1:0] cnt_value = '0;
  logic         step_ready;
  logic         cnt_we;
  logic [W-1:0] cnt_din;
  logic         iter_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;
`ifdef LOOP_CNT_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  loop_counter_ctrl #(.CNT_W(W)) dut (
    .CLK          (clk),
    .RST_ASYNC_N  (rst_n),
    .START        (start),
    .LOOP_LIMIT   (loop_limit),
    .CNT_VALUE    (cnt_value),
    .STEP_READY   (step_ready),
`ifdef LOOP_CNT_ABORT_EN
    .ABORT        (abort),
    .ABORTED      (aborted),
`endif
    .CNT_WRITE_EN (cnt_we),
    .CNT_DATA_IN  (cnt_din),
    .ITER_VALID   (iter_valid),
    .BUSY         (busy),
    .DONE         (done),
    .DBG_STATE    (dbg_state)
  );

  // External counter storage register driven by the sequencer's write port.
  always @(posedge clk) begin
    if (cnt_we) cnt_value <= cnt_din;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W:0]   exp_q[$];     // {is_done, index}
  logic [W-1:0] exp_wr_q[$];  // expected counter write data, in order
  int mon_busy = 0;
  int mon_iv   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares every write, transfer and DONE against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 0;
      mon_iv   = 0;
    end else begin
      if (!busy) begin
        check("idle_quiet", {29'd0, iter_valid, done, cnt_we}, 32'd0);
      end else begin
        mon_busy++;
        if (iter_valid) mon_iv++;
      end
      if (cnt_we) begin
        if (exp_wr_q.size() == 0) fail_now("unexpected_write");
        else check("write_data", 32'(cnt_din), 32'(exp_wr_q.pop_front()));
      end
      if (iter_valid && step_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_transfer");
        else check("transfer_index", 32'({1'b0, cnt_value}), 32'(exp_q.pop_front()));
      end
      if (done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else check("done_event", 32'({1'b1, {W{1'b0}}}), 32'(exp_q.pop_front()));
        // CLEAR and FINISH add one busy cycle each to the issuing cycles.
        check("busy_span", mon_busy, mon_iv + 2);
        mon_busy = 0;
        mon_iv   = 0;
      end
`ifdef LOOP_CNT_ABORT_EN
      if (aborted) begin
        mon_busy = 0;
        mon_iv   = 0;
      end
`endif
    end
  end

  // ---------------- driver ----------------
  function automatic logic pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'(c % 2);
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push_loop(input int n);
    exp_wr_q.push_back('0);
    for (int i = 1; i < n; i++) exp_wr_q.push_back(W'(i));
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, W'(i)});
    exp_q.push_back({1'b1, {W{1'b0}}});
  endtask

  // mode: 0 ready held high, 1 ready toggles, 2 ready random.
  task automatic run_loop(input int n, input int mode, input bit noisy);
    int  first_iv;
    int  busy_seen;
    int  lat;
    bit  got_done;
    push_loop(n);
    @(posedge clk); #1;
    start      = 1'b1;
    loop_limit = W'(n);
    step_ready = pick_ready(mode, 0);
    @(negedge clk);
    check("start_cycle_no_busy", {31'd0, busy}, 32'd0);
    first_iv  = -1;
    busy_seen = 0;
    lat       = 0;
    got_done  = 0;
    for (int c = 1; c <= 200 && !got_done; c++) begin
      @(posedge clk); #1;
      start      = noisy ? logic'($urandom_range(0, 1)) : 1'b0;
      loop_limit = W'($urandom);
      step_ready = pick_ready(mode, c);
      @(negedge clk);
      if (busy) busy_seen++;
      if (iter_valid && first_iv < 0) first_iv = c;
      if (done) begin
        got_done = 1;
        lat      = c;
      end
    end
    if (!got_done) begin
      fail_now("done_timeout");
    end else begin
      check("counter_left", 32'(cnt_value), (n == 0) ? 32'd0 : 32'(n - 1));
      if (n == 0) check("no_iter_for_zero", first_iv, -1);
      else        check("first_iter_latency", first_iv, 2);
      if (mode == 0) begin
        check("done_latency", lat, (n == 0) ? 2 : n + 2);
        check("busy_cycles", busy_seen, (n == 0) ? 2 : n + 2);
      end
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      start      = 1'b0;
      step_ready = logic'($urandom_range(0, 1));
      loop_limit = W'($urandom);
    end
  endtask

  task automatic reset_mid_issue();
    push_loop(10);
    @(posedge clk); #1;
    start = 1'b1; loop_limit = W'(10); step_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_reset_in_issue", {31'd0, iter_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, busy, iter_valid, done, cnt_we, dbg_state}, 32'd0);
    exp_q.delete();
    exp_wr_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    idle_cycles(4);
    @(negedge clk);
    check("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

`ifdef LOOP_CNT_ABORT_EN
  task automatic abort_test();
    exp_wr_q.push_back('0);
    for (int i = 1; i <= 4; i++) exp_wr_q.push_back(W'(i));
    exp_wr_q.push_back('0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, W'(i)});
    @(posedge clk); #1;
    start = 1'b1; loop_limit = W'(8); step_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (c == 6);
    end
    @(negedge clk);
    check("abort_cycle_outputs", {29'd0, iter_valid, done, cnt_we}, 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("aborted_pulse", {30'd0, aborted, busy}, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("aborted_once", {31'd0, aborted}, 32'd0);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    step_ready = 1'b0;
    loop_limit = '0;
`ifdef LOOP_CNT_ABORT_EN
    abort      = 1'b0;
`endif
    #1;
    check("reset_outputs", {26'd0, busy, iter_valid, done, cnt_we, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycles(2);

    run_loop(3, 0, 1'b0);
    idle_cycles(2);
    run_loop(3, 1, 1'b0);
    idle_cycles(1);
    run_loop(0, 0, 1'b0);
    idle_cycles(1);
    run_loop(15, 0, 1'b1);
    run_loop(15, 2, 1'b1);  // back-to-back START the cycle after DONE
    run_loop(1, 0, 1'b0);
    idle_cycles(1);

    reset_mid_issue();

    for (int r = 0; r < 12; r++) begin
      run_loop(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end

`ifdef LOOP_CNT_ABORT_EN
    idle_cycles(1);
    abort_test();
`endif

    idle_cycles(4);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
